muldiv_sched: RTL

MULDIV_SCHED -- requirements
Module: muldiv_sched

---
 rtl/muldiv_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sched.sv
// muldiv_sched: issue scheduler for a shared multiply/divide datapath.
//
// Two requesters compete for a single operand bus that feeds a LAT-deep multiply pipeline and a
// LAT-deep divide pipeline. At most one operation is issued per cycle. When both requesters are
// eligible, round-robin arbitration picks the winner. A tracking shift register follows each
// issued operation, so that the result leaves with its owner, op type and tag exactly LAT cycles
// after the handshake. Each requester may have up to MAX_OUT operations in flight.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   req{0,1}_valid/op/tag    requester operation (op: 0 = multiply, 1 = divide)
//   req{0,1}_ready           grant this cycle (combinational)
//   issue_sel                requester whose operands are muxed onto the shared bus
//   mul_issue, div_issue     issue strobe into the multiply / divide pipeline
//   res_valid/src/op/tag     retiring result (fields are zero when res_valid is low)
//   pend0, pend1             in-flight count per requester
//   busy                     any tracking stage holds a valid entry
module muldiv_sched #(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned LAT     = 2,
  parameter int unsigned MAX_OUT = 2,
  localparam int unsigned PW     = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  output logic             issue_sel,
  output logic             mul_issue,
  output logic             div_issue,
  output logic             res_valid,
  output logic             res_src,
  output logic             res_op,
  output logic [TAG_W-1:0] res_tag,
  output logic [PW-1:0]    pend0,
  output logic [PW-1:0]    pend1,
  output logic             busy
);

  localparam logic [PW-1:0] MaxOut = PW'(MAX_OUT);

  typedef struct packed {
    logic             valid;
    logic             src;
    logic             op;
    logic [TAG_W-1:0] tag;
  } trk_t;

  trk_t          trk_q [LAT];
  trk_t          new_ent;
  logic [PW-1:0] pend0_q, pend1_q;
  logic          prio_q;  // requester favoured on a tie
  logic          sel_q;   // last granted requester, drives issue_sel when idle

  logic          elig0, elig1;
  logic          grant, gnt_idx, gnt_op;
  logic [TAG_W-1:0] gnt_tag;
  logic          inc0, inc1, dec0, dec1;

  // Arbitration. Reset gates eligibility so that no handshake is seen while reset is held.
  always_comb begin
    elig0   = ~reset & req0_valid & (pend0_q < MaxOut);
    elig1   = ~reset & req1_valid & (pend1_q < MaxOut);
    grant   = elig0 | elig1;
    gnt_idx = (elig0 & elig1) ? prio_q : elig1;
    gnt_op  = gnt_idx ? req1_op  : req0_op;
    gnt_tag = gnt_idx ? req1_tag : req0_tag;
  end

  always_comb begin
    req0_ready = grant & ~gnt_idx;
    req1_ready = grant &  gnt_idx;
    mul_issue  = grant & ~gnt_op;
    div_issue  = grant &  gnt_op;
    issue_sel  = grant ? gnt_idx : sel_q;
  end

  // Empty slots carry zero payload so that the result fields read zero without extra gating.
  always_comb begin
    new_ent = '0;
    if (grant) begin
      new_ent.valid = 1'b1;
      new_ent.src   = gnt_idx;
      new_ent.op    = gnt_op;
      new_ent.tag   = gnt_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) trk_q[i] <= '0;
    end else begin
      trk_q[0] <= new_ent;
      for (int i = 1; i < LAT; i++) trk_q[i] <= trk_q[i-1];
    end
  end

  always_comb begin
    res_valid = trk_q[LAT-1].valid;
    res_src   = trk_q[LAT-1].valid ? trk_q[LAT-1].src : 1'b0;
    res_op    = trk_q[LAT-1].valid ? trk_q[LAT-1].op  : 1'b0;
    res_tag   = trk_q[LAT-1].valid ? trk_q[LAT-1].tag : '0;
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LAT; i++) busy = busy | trk_q[i].valid;
  end

  // Arbitration state moves only on a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
      sel_q  <= 1'b0;
    end else if (grant) begin
      prio_q <= ~gnt_idx;
      sel_q  <= gnt_idx;
    end
  end

  // In-flight counters; a simultaneous grant and retire for the same requester cancel out.
  always_comb begin
    inc0 = req0_ready;
    inc1 = req1_ready;
    dec0 = res_valid & ~res_src;
    dec1 = res_valid &  res_src;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend0_q <= '0;
      pend1_q <= '0;
    end else begin
      if (inc0 && !dec0 && pend0_q != MaxOut)   pend0_q <= pend0_q + PW'(1);
      else if (dec0 && !inc0 && pend0_q != '0)  pend0_q <= pend0_q - PW'(1);
      if (inc1 && !dec1 && pend1_q != MaxOut)   pend1_q <= pend1_q + PW'(1);
      else if (dec1 && !inc1 && pend1_q != '0)  pend1_q <= pend1_q - PW'(1);
    end
  end

  assign pend0 = pend0_q;
  assign pend1 = pend1_q;

  // Hitting either counter limit means the tracking and the counters disagree.
  a_pend0_over : assert property (@(posedge clk) disable iff (reset)
    !(inc0 && !dec0 && pend0_q == MaxOut)) else $error("pend0 overflow");
  a_pend0_under : assert property (@(posedge clk) disable iff (reset)
    !(dec0 && !inc0 && pend0_q == '0)) else $error("pend0 underflow");
  a_pend1_over : assert property (@(posedge clk) disable iff (reset)
    !(inc1 && !dec1 && pend1_q == MaxOut)) else $error("pend1 overflow");
  a_pend1_under : assert property (@(posedge clk) disable iff (reset)
    !(dec1 && !inc1 && pend1_q == '0)) else $error("pend1 underflow");

endmodule
